// File: rtl/mem_word_initiator.sv
// Word-to-byte initiator: splits word read/write commands into little-endian byte
// transactions on a request/ack memory bus and returns one response per command.
module mem_word_initiator #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BYTES   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [8*BYTES-1:0]   cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*BYTES-1:0]   rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata
);

  localparam int unsigned IdxW = $clog2(BYTES) + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [CntW-1:0]    tcnt_q, tcnt_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [8*BYTES-1:0] wdata_q, wdata_d;
  logic [8*BYTES-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StXfer;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          idx_d   = '0;
          tcnt_d  = '0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      StXfer: begin
        if (mem_ack) begin
          if (!write_q) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
              if (idx_q == IdxW'(i)) rdata_d[8*i +: 8] = mem_rdata;
            end
          end
          tcnt_d  = '0;
          // wdata_q is a shift register: the current byte is always in [7:0]
          wdata_d = wdata_q >> 8;
          if (idx_q == IdxW'(BYTES - 1)) begin
            state_d = StResp;
          end else begin
            idx_d  = idx_q + IdxW'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end else if (tcnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tcnt_d = tcnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tcnt_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    mem_req   = (state_q == StXfer);
    mem_we    = mem_req & write_q;
    mem_addr  = mem_req ? addr_q : '0;
    mem_wdata = mem_req ? wdata_q[7:0] : 8'h00;
  end

endmodule

// File: tb/tb_mem_word_initiator.sv
// Bench for mem_word_initiator: byte-level responder with random ack delay and stalls,
// word-level reference memory, and per-command checks of bytes, addresses and responses.
module tb_mem_word_initiator;
  localparam int AW = 10;
  localparam int NB = 4;
  localparam int TO = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_word_initiator #(.ADDR_W(AW), .BYTES(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder memory (written by DUT bytes) and reference memory (updated per command)
  logic [7:0] resp_mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  int            max_delay = 0;
  int            stall_byte = -1;
  int            wait_cnt = 0;
  int            byte_no = 0;
  logic          cur_wr = 1'b0;
  logic [AW-1:0] ack_addr_q [$];
  logic [7:0]    ack_wdata_q [$];
  logic          prev_req = 1'b0, prev_ack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_wdata = '0;
  int            rsp_cnt = 0;
  int            n_cmds = 0;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem_req) begin
        mem_ack = 1'b0;
        byte_no = 0;
        wait_cnt = $urandom_range(max_delay, 0);
      end else begin
        if (prev_req && !prev_ack) begin
          check_eq("addr_stable", 32'(mem_addr), 32'(prev_addr));
          check_eq("wdata_stable", 32'(mem_wdata), 32'(prev_wdata));
        end
        if (byte_no == stall_byte) begin
          mem_ack = 1'b0;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
          mem_ack = 1'b0;
        end else begin
          mem_ack = 1'b1;
          check_eq("mem_we", 32'(mem_we), 32'(cur_wr));
          mem_rdata = resp_mem[mem_addr];
          if (mem_we) resp_mem[mem_addr] = mem_wdata;
          ack_addr_q.push_back(mem_addr);
          ack_wdata_q.push_back(mem_wdata);
          byte_no++;
          wait_cnt = $urandom_range(max_delay, 0);
        end
      end
      prev_req = mem_req && rst_n;
      prev_ack = mem_ack;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  always @(posedge clk) if (rst_n && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;

  // One command end to end; stall_at >= 0 makes that byte never acked (timeout).
  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                         input int bp, input int stall_at, input bit chk_lat,
                         output logic [31:0] got_r);
    logic [31:0] exp_r;
    logic        exp_e;
    int          nb;
    int          k;
    nb = (stall_at >= 0) ? stall_at : NB;
    exp_e = (stall_at >= 0);
    exp_r = '0;
    for (int i = 0; i < nb; i++) begin
      if (wr) ref_mem[(int'(a) + i) % DEPTH] = wd[8*i +: 8];
      else    exp_r[8*i +: 8] = ref_mem[(int'(a) + i) % DEPTH];
    end
    ack_addr_q.delete();
    ack_wdata_q.delete();
    stall_byte = stall_at;
    cur_wr = wr;
    n_cmds++;
    @(negedge clk);
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = wd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("rsp_arrived", 32'(rsp_valid), 32'd1);
    if (chk_lat) check_eq("rsp_latency", 32'(k), 32'(NB + 1));
    got_r = rsp_rdata;
    check_eq(wr ? "wr_rdata" : "rd_rdata", rsp_rdata, exp_r);
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_e));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rdata", rsp_rdata, exp_r);
      check_eq("bp_err", 32'(rsp_err), 32'(exp_e));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_dropped", 32'(rsp_valid), 32'd0);
    check_eq("cmd_ready_back", 32'(cmd_ready), 32'd1);
    check_eq("n_bytes", 32'(ack_addr_q.size()), 32'(nb));
    for (int i = 0; i < nb && i < ack_addr_q.size(); i++) begin
      check_eq("byte_addr", 32'(ack_addr_q[i]), 32'((int'(a) + i) % DEPTH));
      if (wr) check_eq("byte_wdata", 32'(ack_wdata_q[i]), 32'(wd[8*i +: 8]));
    end
    stall_byte = -1;
  endtask

  initial begin
    logic [31:0]   r;
    logic [AW-1:0] a;
    logic [31:0]   w;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'($urandom);
      resp_mem[i] = ref_mem[i];
    end
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back, no delays, latency checked
    max_delay = 0;
    run_cmd(1'b1, 10'h004, 32'hA1B2C3D4, 0, -1, 1'b1, r);
    check_eq("t2_mem_bytes", {resp_mem[7], resp_mem[6], resp_mem[5], resp_mem[4]},
             32'hA1B2C3D4);
    run_cmd(1'b0, 10'h004, 32'h0, 0, -1, 1'b1, r);
    check_eq("t2_readback", r, 32'hA1B2C3D4);

    // Address wrap
    run_cmd(1'b0, 10'h3FE, 32'h0, 0, -1, 1'b1, r);

    // Backpressure on both sides
    max_delay = 3;
    a = AW'($urandom);
    w = $urandom;
    run_cmd(1'b1, a, w, 3, -1, 1'b0, r);
    run_cmd(1'b0, a, 32'h0, 3, -1, 1'b0, r);
    check_eq("bp_readback", r, w);

    // Timeouts: read stalls on byte 2, write stalls on byte 1
    max_delay = 0;
    run_cmd(1'b0, 10'h010, 32'h0, 0, 2, 1'b0, r);
    check_eq("to_upper_zero", 32'(r[31:16]), 32'd0);
    run_cmd(1'b1, 10'h020, $urandom, 1, 1, 1'b0, r);
    run_cmd(1'b0, 10'h020, 32'h0, 0, -1, 1'b0, r);

    // Reset during transfer, after byte 1 ack
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 10'h100;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_mem_req", 32'(mem_req), 32'd0);
    check_eq("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_cmd(1'b0, 10'h100, 32'h0, 0, -1, 1'b1, r);

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      max_delay = $urandom_range(3, 0);
      run_cmd(1'($urandom), AW'($urandom), $urandom, $urandom_range(3, 0), -1, 1'b0, r);
    end

    @(negedge clk);
    check_eq("rsp_count", 32'(rsp_cnt), 32'(n_cmds));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
